vic_bus_if: RTL and testbench
=============================

Name: vic_bus_if

Overview:
- Front-end bus interface between the VIC-20 expansion port and the MIDI register block.
- Synchronises the asynchronous 6502 bus (phi2, I/O select, R/W) into the local clock domain.
- Latches the 3-bit register index that feeds the downstream 3-to-8 register-select decoder.
- Emits exactly one read or write strobe per qualified bus access.
- Requires clk >= 8x phi2 (nominal 16 MHz clk vs 1 MHz phi2).

Parameters:
- SYNC_STAGES, 2: flops per synchroniser chain (min 2).
- SETTLE_CYCLES, 2: clk cycles after a synchronised access start before the address is captured (min 1).
- TIMEOUT_CYCLES, 64: HOLD watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- phi2  in  1  VIC-20 phase-2 clock, asynchronous
- io_sel_n  in  1  I/O block select, active low, asynchronous
- rw  in  1  bus R/W; 1 = read
- addr  in  3  bus A[2:0]
- data_in  in  8  bus D[7:0]
- reg_sel  out  3  latched register index, to decoder
- rd_stb  out  1  one-clk read strobe
- wr_stb  out  1  one-clk write strobe
- wr_data  out  8  captured write data, valid when wr_stb = 1
- active  out  1  high while a qualified access is in progress (gates the read-data bus driver)
- err_timeout  out  1  one-clk pulse on watchdog abort

Behaviour:
- Reset state:
  - Clock and reset are fixed as: one clock `clk`; reset `reset` is asynchronous and active-high.
  - All outputs are 0, the FSM is in IDLE, and the settle/timeout counters are 0.
- Synchronisers:
  - phi2, io_sel_n and rw each pass through SYNC_STAGES flops.
  - io_sel_n synchroniser chains reset to 1; the others reset to 0.
  - phi2_s, sel_s and rw_s denote the final stages; phi2_1 denotes the first stage of phi2.
- addr and data_in are sampled raw; they are stable whenever phi2 is high.
- access_s = phi2_s & ~sel_s.
- FSM states:
  - IDLE:
    - On access_s = 1, go to SETTLE and load the counter with SETTLE_CYCLES-1.
  - SETTLE:
    - If access_s drops, return to IDLE with no strobe (glitch rejection).
    - Otherwise decrement the counter; at 0 go to CAPTURE.
  - CAPTURE (1 clk):
    - Latch reg_sel <= addr and rw_l <= rw_s.
    - If rw_s = 1, pulse rd_stb during this cycle.
    - Go to HOLD.
  - HOLD:
    - Every clk where phi2_1 = 1, update the shadow register wr_shadow <= data_in.
    - When access_s = 0: if rw_l = 0, pulse wr_stb with wr_data = wr_shadow; then go to IDLE.
- active:
  - 1 in SETTLE, CAPTURE and HOLD; 0 in IDLE.
  - Registered output, so it lags access_s by 1 clk.
- Latency:
  - rd_stb asserts SYNC_STAGES + SETTLE_CYCLES + 1 clks after raw phi2/select assertion.
  - wr_stb asserts SYNC_STAGES + 1 clks after raw phi2 falls.
- Strobe rules:
  - rd_stb and wr_stb are never high together.
  - At most one strobe per access.
  - A new access is not accepted until IDLE has been visited for at least 1 clk.
- Boundary cases:
  - Select deasserts while phi2 is still high: treated as end of access, same as a phi2 fall.
  - rw changes mid-access: ignored after CAPTURE.
  - reg_sel and wr_data hold their values between accesses.
  - Reset mid-access: immediate return to the reset state; no strobe.
  - Counter width is $clog2 of the larger of SETTLE_CYCLES and TIMEOUT_CYCLES, plus 1.

Optional Feature:
- Macro: VIC_BUS_TIMEOUT_EN.
- Defined:
  - A counter runs while in HOLD.
  - On reaching TIMEOUT_CYCLES, the FSM forces IDLE, pulses err_timeout for 1 clk and suppresses wr_stb for that access.
  - The counter clears on leaving HOLD.
- Undefined: no counter; err_timeout is tied to 0; HOLD waits indefinitely.

Decomposition:
- Package vic_bus_pkg holds:
  - the state enum (IDLE, SETTLE, CAPTURE, HOLD);
  - REG_IDX_W = 3;
  - named register-index constants (ACIA_CTRL = 0, ACIA_DATA = 1, ...) shared with the decoder consumer.
- Sub-module sync_bit:
  - parameterised SYNC_STAGES chain with a reset-value parameter;
  - instantiated three times.

Test Plan:
- Read access: phi2 high for 500 ns, io_sel_n = 0, rw = 1, addr = 3'd5 -> one rd_stb, reg_sel = 5, wr_stb never asserted, active high throughout.
- Write access: rw = 0, addr = 3'd1, data_in 8'hXX early then 8'h9C for the last 200 ns of phi2 high -> one wr_stb after phi2 fall with wr_data = 8'h9C, reg_sel = 1.
- Glitch rejection: io_sel_n low for 1 clk only while phi2 is high -> no strobe, active returns to 0, FSM back in IDLE.
- Back-to-back writes to addr 0 then 7 in consecutive phi2 cycles -> two wr_stb, reg_sel 0 then 7, no missed or duplicated strobe.
- Reset mid-HOLD of a write -> all outputs 0 at once, no wr_stb; the next access completes normally.
- With VIC_BUS_TIMEOUT_EN and TIMEOUT_CYCLES = 16: phi2 held high for 40 clks -> err_timeout pulses at HOLD + 16, no wr_stb, FSM in IDLE.

Source files
------------

// File: rtl/vic_bus_pkg.sv
// Shared types and register-index constants for the VIC-20 expansion-port front end
// and the downstream MIDI register-select decoder.
package vic_bus_pkg;

    localparam int REG_IDX_W = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2,
        HOLD    = 2'd3
    } bus_state_e;

    localparam logic [REG_IDX_W-1:0] ACIA_CTRL = 3'd0;
    localparam logic [REG_IDX_W-1:0] ACIA_DATA = 3'd1;
    localparam logic [REG_IDX_W-1:0] ACIA_STAT = 3'd2;
    localparam logic [REG_IDX_W-1:0] ACIA_CMD  = 3'd3;
    localparam logic [REG_IDX_W-1:0] MIDI_THRU = 3'd4;
    localparam logic [REG_IDX_W-1:0] MIDI_CFG  = 3'd5;
    localparam logic [REG_IDX_W-1:0] MIDI_IRQ  = 3'd6;
    localparam logic [REG_IDX_W-1:0] MIDI_ID   = 3'd7;

    // Shared settle/timeout counter width: one spare bit above the larger limit.
    function automatic int cnt_width(input int a, input int b);
        return $clog2((a > b) ? a : b) + 1;
    endfunction

endpackage

// File: rtl/vic_bus_if_sync_bit.sv
// Multi-flop synchroniser for one asynchronous bus line; exposes the first stage
// as well so callers can get an early (unfiltered-by-depth) view of the line.
module sync_bit #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic q_first
);

    logic [SYNC_STAGES-1:0] chain_q;
    logic [SYNC_STAGES-1:0] chain_d;

    always_comb begin
        chain_d = {chain_q[SYNC_STAGES-2:0], d};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain_q <= {SYNC_STAGES{RESET_VAL}};
        end else begin
            chain_q <= chain_d;
        end
    end

    assign q       = chain_q[SYNC_STAGES-1];
    assign q_first = chain_q[0];

endmodule

// File: rtl/vic_bus_if.sv
// VIC-20 expansion-port bus front end: synchronises phi2/select/rw, latches the register
// index and issues one rd/wr strobe per access. Optional HOLD watchdog: VIC_BUS_TIMEOUT_EN.
module vic_bus_if
    import vic_bus_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int SETTLE_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 phi2,
    input  logic                 io_sel_n,
    input  logic                 rw,
    input  logic [REG_IDX_W-1:0] addr,
    input  logic [7:0]           data_in,
    output logic [REG_IDX_W-1:0] reg_sel,
    output logic                 rd_stb,
    output logic                 wr_stb,
    output logic [7:0]           wr_data,
    output logic                 active,
    output logic                 err_timeout
);

    localparam int CNT_W = cnt_width(SETTLE_CYCLES, TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    logic phi2_s, phi2_1, sel_s, rw_s;
    logic sel_1_unused, rw_1_unused;
    logic access_s, start_ok;

    sync_bit #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_phi2 (
        .clk(clk), .rst(reset), .d(phi2), .q(phi2_s), .q_first(phi2_1)
    );
    sync_bit #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_sel (
        .clk(clk), .rst(reset), .d(io_sel_n), .q(sel_s), .q_first(sel_1_unused)
    );
    sync_bit #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_rw (
        .clk(clk), .rst(reset), .d(rw), .q(rw_s), .q_first(rw_1_unused)
    );

    assign access_s = phi2_s & ~sel_s;

    bus_state_e           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [REG_IDX_W-1:0] reg_sel_q, reg_sel_d;
    logic                 rw_l_q, rw_l_d;
    logic [7:0]           wr_shadow_q, wr_shadow_d;
    logic [7:0]           wr_data_q, wr_data_d;
    logic                 rd_stb_q, rd_stb_d;
    logic                 wr_stb_q, wr_stb_d;
    logic                 active_q, active_d;

`ifdef VIC_BUS_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic err_q, err_d;
    // After an abort, wait for the stuck access to end before accepting another.
    logic lock_q, lock_d;
    assign start_ok    = access_s & ~lock_q;
    assign err_timeout = err_q;
`else
    assign start_ok    = access_s;
    assign err_timeout = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        reg_sel_d   = reg_sel_q;
        rw_l_d      = rw_l_q;
        wr_shadow_d = wr_shadow_q;
        wr_data_d   = wr_data_q;
        rd_stb_d    = 1'b0;
        wr_stb_d    = 1'b0;
`ifdef VIC_BUS_TIMEOUT_EN
        err_d       = 1'b0;
        lock_d      = lock_q;
        if (!access_s) begin
            lock_d = 1'b0;
        end
`endif
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (start_ok) begin
                    state_d = SETTLE;
                    cnt_d   = SETTLE_LOAD;
                end
            end
            SETTLE: begin
                if (!access_s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    // Index and direction are taken on entry so reg_sel is valid with rd_stb.
                    state_d   = CAPTURE;
                    reg_sel_d = addr;
                    rw_l_d    = rw_s;
                    rd_stb_d  = rw_s;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            CAPTURE: begin
                state_d = HOLD;
                cnt_d   = '0;
            end
            HOLD: begin
                if (phi2_1) begin
                    wr_shadow_d = data_in;
                end
                if (!access_s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    if (!rw_l_q) begin
                        wr_stb_d  = 1'b1;
                        wr_data_d = wr_shadow_q;
                    end
                end
`ifdef VIC_BUS_TIMEOUT_EN
                else if (cnt_q == TIMEOUT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    err_d   = 1'b1;
                    lock_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        active_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            reg_sel_q   <= '0;
            rw_l_q      <= 1'b0;
            wr_shadow_q <= '0;
            wr_data_q   <= '0;
            rd_stb_q    <= 1'b0;
            wr_stb_q    <= 1'b0;
            active_q    <= 1'b0;
`ifdef VIC_BUS_TIMEOUT_EN
            err_q       <= 1'b0;
            lock_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            reg_sel_q   <= reg_sel_d;
            rw_l_q      <= rw_l_d;
            wr_shadow_q <= wr_shadow_d;
            wr_data_q   <= wr_data_d;
            rd_stb_q    <= rd_stb_d;
            wr_stb_q    <= wr_stb_d;
            active_q    <= active_d;
`ifdef VIC_BUS_TIMEOUT_EN
            err_q       <= err_d;
            lock_q      <= lock_d;
`endif
        end
    end

    assign reg_sel = reg_sel_q;
    assign rd_stb  = rd_stb_q;
    assign wr_stb  = wr_stb_q;
    assign wr_data = wr_data_q;
    assign active  = active_q;

endmodule

// File: tb/tb_vic_bus_if.sv
// Randomised bus-access bench for vic_bus_if against a per-access transaction model.
`timescale 1ns/1ps
module tb_vic_bus_if;

    localparam int SYNC   = 2;
    localparam int SETTLE = 2;
    localparam int TMO    = 16;
    localparam int RD_LAT = SYNC + SETTLE + 1;
    localparam int WR_LAT = SYNC + 1;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       phi2 = 1'b0;
    logic       io_sel_n = 1'b1;
    logic       rw = 1'b0;
    logic [2:0] addr = 3'd0;
    logic [7:0] data_in = 8'd0;
    logic [2:0] reg_sel;
    logic       rd_stb, wr_stb, active, err_timeout;
    logic [7:0] wr_data;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int         c;
        logic [2:0] r;
        logic [7:0] d;
    } ev_t;

    ev_t rd_q[$];
    ev_t wr_q[$];
    int  err_q[$];

    logic [2:0] exp_reg   = 3'd0;
    logic [7:0] exp_wdata = 8'd0;

    vic_bus_if #(
        .SYNC_STAGES(SYNC), .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .reset(reset), .phi2(phi2), .io_sel_n(io_sel_n), .rw(rw),
        .addr(addr), .data_in(data_in), .reg_sel(reg_sel), .rd_stb(rd_stb),
        .wr_stb(wr_stb), .wr_data(wr_data), .active(active), .err_timeout(err_timeout)
    );

    always #31.25 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        ev_t e;
        if (!reset) begin
            e.c = cyc;
            e.r = reg_sel;
            e.d = wr_data;
            if (rd_stb) rd_q.push_back(e);
            if (wr_stb) wr_q.push_back(e);
            if (err_timeout) err_q.push_back(cyc);
            if (rd_stb && wr_stb) chk("stb_overlap", 32'(wr_stb), 32'd0);
        end
    end

    task automatic clear_q();
        rd_q.delete();
        wr_q.delete();
        err_q.delete();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic end_checks();
        chk("active_idle", 32'(active), 32'd0);
        chk("reg_sel_hold", 32'(reg_sel), 32'(exp_reg));
        chk("wr_data_hold", 32'(wr_data), 32'(exp_wdata));
        chk("err_none", err_q.size(), 0);
        clear_q();
    endtask

    // One phi2 cycle: high for hi clks, then low for 8 clks, then check the outcome.
    task automatic do_access(input logic is_rd, input logic [2:0] a, input logic [7:0] d,
                             input int hi, input logic flip, input logic sel_first);
        int t0, t1;
        tick();
        t0 = cyc;
        phi2 = 1'b1; io_sel_n = 1'b0; rw = is_rd; addr = a; data_in = 8'($urandom);
        for (int k = 1; k <= hi; k++) begin
            tick();
            if (k == 4) chk("active_mid", 32'(active), 32'd1);
            if (k == hi - 3) data_in = d;
            if (flip && k == 6) rw = ~is_rd;
        end
        t1 = cyc;
        io_sel_n = 1'b1;
        if (!sel_first) phi2 = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 2) phi2 = 1'b0;
            if (k == 3) begin
                data_in = 8'($urandom);
                addr    = 3'($urandom);
                rw      = 1'($urandom);
            end
        end
        if (is_rd) begin
            chk("rd_count", rd_q.size(), 1);
            chk("wr_on_read", wr_q.size(), 0);
            if (rd_q.size() > 0) begin
                chk("rd_latency", rd_q[0].c - t0, RD_LAT);
                chk("rd_reg_sel", 32'(rd_q[0].r), 32'(a));
            end
            exp_reg = a;
        end else begin
            chk("wr_count", wr_q.size(), 1);
            chk("rd_on_write", rd_q.size(), 0);
            if (wr_q.size() > 0) begin
                chk("wr_latency", wr_q[0].c - t1, WR_LAT);
                chk("wr_reg_sel", 32'(wr_q[0].r), 32'(a));
                chk("wr_data", 32'(wr_q[0].d), 32'(d));
            end
            exp_reg   = a;
            exp_wdata = d;
        end
        end_checks();
    endtask

    task automatic do_glitch();
        tick();
        phi2 = 1'b1; io_sel_n = 1'b1; rw = 1'($urandom); addr = 3'($urandom);
        tick();
        tick();
        io_sel_n = 1'b0;
        tick();
        io_sel_n = 1'b1;
        repeat (5) tick();
        phi2 = 1'b0;
        repeat (8) tick();
        chk("glitch_rd", rd_q.size(), 0);
        chk("glitch_wr", wr_q.size(), 0);
        end_checks();
    endtask

    task automatic do_reset_mid_hold();
        tick();
        phi2 = 1'b1; io_sel_n = 1'b0; rw = 1'b0; addr = 3'd6; data_in = 8'h5A;
        repeat (8) tick();
        chk("pre_reset_active", 32'(active), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_rd_stb", 32'(rd_stb), 32'd0);
        chk("rst_wr_stb", 32'(wr_stb), 32'd0);
        chk("rst_active", 32'(active), 32'd0);
        chk("rst_reg_sel", 32'(reg_sel), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        phi2 = 1'b0; io_sel_n = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        repeat (8) tick();
        chk("rst_no_wr", wr_q.size(), 0);
        chk("rst_no_rd", rd_q.size(), 0);
        exp_reg   = 3'd0;
        exp_wdata = 8'd0;
        end_checks();
    endtask

`ifdef VIC_BUS_TIMEOUT_EN
    task automatic do_timeout();
        int t0;
        tick();
        t0 = cyc;
        phi2 = 1'b1; io_sel_n = 1'b0; rw = 1'b0; addr = 3'd3; data_in = 8'hA5;
        repeat (40) tick();
        phi2 = 1'b0; io_sel_n = 1'b1;
        repeat (10) tick();
        chk("tmo_count", err_q.size(), 1);
        if (err_q.size() > 0) chk("tmo_time", err_q[0] - t0, RD_LAT + 1 + TMO);
        chk("tmo_no_wr", wr_q.size(), 0);
        chk("tmo_no_rd", rd_q.size(), 0);
        exp_reg = 3'd3;
        err_q.delete();
        end_checks();
    endtask
`endif

    initial begin
        #1000000;
        $display("FAIL watchdog: sim time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        #5 reset = 1'b1;
        #2;
        chk("init_rd_stb", 32'(rd_stb), 32'd0);
        chk("init_wr_stb", 32'(wr_stb), 32'd0);
        chk("init_active", 32'(active), 32'd0);
        chk("init_reg_sel", 32'(reg_sel), 32'd0);
        chk("init_wr_data", 32'(wr_data), 32'd0);
        chk("init_err", 32'(err_timeout), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) tick();

        do_access(1'b1, 3'd5, 8'h00, 8, 1'b0, 1'b0);
        do_access(1'b0, 3'd1, 8'h9C, 8, 1'b0, 1'b0);
        do_glitch();
        do_access(1'b0, 3'd0, 8'h11, 8, 1'b0, 1'b0);
        do_access(1'b0, 3'd7, 8'hE7, 8, 1'b0, 1'b0);
        do_access(1'b1, 3'd2, 8'h00, 8, 1'b0, 1'b1);
        do_access(1'b0, 3'd4, 8'h3C, 9, 1'b1, 1'b1);
        do_reset_mid_hold();
        do_access(1'b0, 3'd2, 8'h77, 8, 1'b0, 1'b0);

        for (int i = 0; i < 30; i++) begin
            int   kind, hi;
            logic flip, sel_first;
            kind      = int'($urandom_range(0, 9));
            hi        = int'($urandom_range(7, 12));
            flip      = (hi >= 8) && ($urandom_range(0, 3) == 0);
            sel_first = ($urandom_range(0, 3) == 0);
            if (kind == 0) do_glitch();
            else do_access(kind < 5, 3'($urandom), 8'($urandom), hi, flip, sel_first);
        end

`ifdef VIC_BUS_TIMEOUT_EN
        do_timeout();
        do_access(1'b0, 3'd6, 8'hC3, 8, 1'b0, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
